// File: rtl/dot2_arbiter_if.sv
// dot2_arbiter_if
//  Bundles the requester handshake, the operand/result bus of the shared
//  two-term multiply-add unit and the tagged response port of dot2_arbiter.
//  Ports (as interface members):
//   req_valid/req_ready      per-requester handshake, req_ready is one-hot
//   req_a1/b1/a2/b2          NREQ packed operand slices, slice i = [i*W +: W]
//   mac_a1/b1/a2/b2, mac_c   registered operands to the unit, result back
//   rsp_valid/rsp_id/rsp_data  tagged result stream to the requesters
//  Modports: slave = the arbiter, master = requesters + unit + response sink.
interface dot2_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 32
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a1;
    logic [NREQ*W-1:0] req_b1;
    logic [NREQ*W-1:0] req_a2;
    logic [NREQ*W-1:0] req_b2;
    logic [W-1:0]      mac_a1;
    logic [W-1:0]      mac_b1;
    logic [W-1:0]      mac_a2;
    logic [W-1:0]      mac_b2;
    logic [W-1:0]      mac_c;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_data;

    modport slave (
        input  req_valid, req_a1, req_b1, req_a2, req_b2, mac_c,
        output req_ready, mac_a1, mac_b1, mac_a2, mac_b2,
               rsp_valid, rsp_id, rsp_data
    );

    modport master (
        output req_valid, req_a1, req_b1, req_a2, req_b2, mac_c,
        input  req_ready, mac_a1, mac_b1, mac_a2, mac_b2,
               rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/dot2_arbiter.sv
// dot2_arbiter
//  Round-robin arbiter sharing one fixed-latency multiply-add unit
//  (C = A1*B1 + A2*B2) among NREQ requesters. One operand set is granted
//  per cycle, registered onto mac_*, and a tag pipe follows it through the
//  unit so the result comes back on rsp_* labelled with its requester id.
//  Ports:
//   clk, reset   clock and synchronous active-high reset
//   bus          dot2_arbiter_if.slave (handshake, unit bus, response)
//   perf_accepts, perf_conflicts  32-bit counters, only when
//                DOT2_ARB_PERF_EN is defined
//  Configuration macro: DOT2_ARB_PERF_EN adds the performance counters.
module dot2_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 32,
    parameter int LAT  = 2
) (
    input  logic                clk,
    input  logic                reset,
    dot2_arbiter_if.slave       bus
`ifdef DOT2_ARB_PERF_EN
    ,
    output logic [31:0]         perf_accepts,
    output logic [31:0]         perf_conflicts
`endif
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDW-1:0]  rrPtr_q, rrPtr_d;
    logic [W-1:0]    macA1_q, macA1_d;
    logic [W-1:0]    macB1_q, macB1_d;
    logic [W-1:0]    macA2_q, macA2_d;
    logic [W-1:0]    macB2_q, macB2_d;
    logic [LAT-1:0]  tagValid_q, tagValid_d;
    logic [IDW-1:0]  tagId_q [LAT];
    logic [IDW-1:0]  tagId_d [LAT];
    logic            rspValid_q, rspValid_d;
    logic [IDW-1:0]  rspId_q, rspId_d;

    logic            anyValid;
    logic            accept;
    logic [IDW-1:0]  winner;
    logic [IDW-1:0]  scanIdx;
    logic [NREQ-1:0] reqReady;
    logic [W-1:0]    selA1, selB1, selA2, selB2;

    // Scan starting just after the last winner; the first valid requester
    // found wins, so the previous winner gets lowest priority.
    always_comb begin
        anyValid = 1'b0;
        winner   = '0;
        scanIdx  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            scanIdx = IDW'((int'(rrPtr_q) + k) % NREQ);
            if (!anyValid && bus.req_valid[scanIdx]) begin
                anyValid = 1'b1;
                winner   = scanIdx;
            end
        end
    end

    // Grants are suppressed during reset so nothing is accepted that the
    // reset is about to discard.
    assign accept = anyValid && !reset;

    always_comb begin
        reqReady = '0;
        selA1    = '0;
        selB1    = '0;
        selA2    = '0;
        selB2    = '0;
        for (int i = 0; i < NREQ; i++) begin
            reqReady[i] = accept && (winner == IDW'(i));
            if (winner == IDW'(i)) begin
                selA1 = bus.req_a1[i*W +: W];
                selB1 = bus.req_b1[i*W +: W];
                selA2 = bus.req_a2[i*W +: W];
                selB2 = bus.req_b2[i*W +: W];
            end
        end
    end

    // Stage 0 of the tag pipe lines up with the mac_* registers; the extra
    // response register lines the tag up with the unit's result on mac_c.
    always_comb begin
        rrPtr_d       = accept ? winner : rrPtr_q;
        macA1_d       = accept ? selA1 : macA1_q;
        macB1_d       = accept ? selB1 : macB1_q;
        macA2_d       = accept ? selA2 : macA2_q;
        macB2_d       = accept ? selB2 : macB2_q;
        tagValid_d    = '0;
        tagValid_d[0] = accept;
        tagId_d[0]    = winner;
        for (int k = 1; k < LAT; k++) begin
            tagValid_d[k] = tagValid_q[k-1];
            tagId_d[k]    = tagId_q[k-1];
        end
        rspValid_d    = tagValid_q[LAT-1];
        rspId_d       = tagId_q[LAT-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rrPtr_q    <= IDW'(NREQ - 1);
            macA1_q    <= '0;
            macB1_q    <= '0;
            macA2_q    <= '0;
            macB2_q    <= '0;
            tagValid_q <= '0;
            for (int k = 0; k < LAT; k++) begin
                tagId_q[k] <= '0;
            end
            rspValid_q <= 1'b0;
            rspId_q    <= '0;
        end else begin
            rrPtr_q    <= rrPtr_d;
            macA1_q    <= macA1_d;
            macB1_q    <= macB1_d;
            macA2_q    <= macA2_d;
            macB2_q    <= macB2_d;
            tagValid_q <= tagValid_d;
            for (int k = 0; k < LAT; k++) begin
                tagId_q[k] <= tagId_d[k];
            end
            rspValid_q <= rspValid_d;
            rspId_q    <= rspId_d;
        end
    end

    assign bus.req_ready = reqReady;
    assign bus.mac_a1    = macA1_q;
    assign bus.mac_b1    = macB1_q;
    assign bus.mac_a2    = macA2_q;
    assign bus.mac_b2    = macB2_q;
    assign bus.rsp_valid = rspValid_q;
    assign bus.rsp_id    = rspId_q;
    assign bus.rsp_data  = bus.mac_c;

`ifdef DOT2_ARB_PERF_EN
    logic [31:0] perfAccepts_q;
    logic [31:0] perfConflicts_q;

    // A conflict is any cycle where two or more requesters compete.
    always_ff @(posedge clk) begin
        if (reset) begin
            perfAccepts_q   <= '0;
            perfConflicts_q <= '0;
        end else begin
            if (accept) begin
                perfAccepts_q <= perfAccepts_q + 32'd1;
            end
            if ($countones(bus.req_valid) >= 2) begin
                perfConflicts_q <= perfConflicts_q + 32'd1;
            end
        end
    end

    assign perf_accepts   = perfAccepts_q;
    assign perf_conflicts = perfConflicts_q;
`endif
endmodule

// File: tb/tb_dot2_arbiter.sv
// tb_dot2_arbiter
//  Drives dot2_arbiter with directed scenarios followed by random traffic,
//  places a real fixed-latency multiply-add unit behind mac_*, and compares
//  every cycle against a queue-based reference of the arbiter's behaviour.
module tb_dot2_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int LAT  = 2;

    typedef struct {
        int           due;
        int           id;
        logic [W-1:0] data;
    } rsp_t;

    logic clk;
    logic reset;

    dot2_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

`ifdef DOT2_ARB_PERF_EN
    logic [31:0] perfAccepts;
    logic [31:0] perfConflicts;
`endif

    dot2_arbiter #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus.slave)
`ifdef DOT2_ARB_PERF_EN
        ,
        .perf_accepts   (perfAccepts),
        .perf_conflicts (perfConflicts)
`endif
    );

    int checkCount = 0;
    int passCount  = 0;

    // Shared multiply-add unit: LAT register stages after the mac_* registers.
    logic [W-1:0] unitPipe [LAT];

    always_ff @(posedge clk) begin
        unitPipe[0] <= bus.mac_a1 * bus.mac_b1 + bus.mac_a2 * bus.mac_b2;
        for (int k = 1; k < LAT; k++) begin
            unitPipe[k] <= unitPipe[k-1];
        end
    end

    assign bus.mac_c = unitPipe[LAT-1];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference state: pointer to last winner, expected responses with due edge.
    rsp_t         expQ[$];
    int           modelPtr       = 0;
    int           edgeCount      = 0;
    logic [W-1:0] modelMac [4];
    int           modelAccepts   = 0;
    int           modelConflicts = 0;

    function automatic int pickWinner(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] sliceOf(input logic [NREQ*W-1:0] v, input int i);
        return v[i*W +: W];
    endfunction

    task automatic checkEq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        logic [NREQ-1:0] expReady;
        int              w;
        w = pickWinner(bus.req_valid, modelPtr);
        expReady = (reset || w < 0) ? '0 : (NREQ'(1) << w);
        checkEq("req_ready", 64'(bus.req_ready), 64'(expReady));
        if (expQ.size() > 0 && expQ[0].due == edgeCount) begin
            checkEq("rsp_valid", 64'(bus.rsp_valid), 64'd1);
            checkEq("rsp_id", 64'(bus.rsp_id), 64'(expQ[0].id));
            checkEq("rsp_data", 64'(bus.rsp_data), 64'(expQ[0].data));
            void'(expQ.pop_front());
        end else begin
            checkEq("rsp_valid_idle", 64'(bus.rsp_valid), 64'd0);
        end
        checkEq("mac_a1", 64'(bus.mac_a1), 64'(modelMac[0]));
        checkEq("mac_b1", 64'(bus.mac_b1), 64'(modelMac[1]));
        checkEq("mac_a2", 64'(bus.mac_a2), 64'(modelMac[2]));
        checkEq("mac_b2", 64'(bus.mac_b2), 64'(modelMac[3]));
`ifdef DOT2_ARB_PERF_EN
        checkEq("perf_accepts", 64'(perfAccepts), 64'(32'(modelAccepts)));
        checkEq("perf_conflicts", 64'(perfConflicts), 64'(32'(modelConflicts)));
`endif
    endtask

    // Reference update at each edge, then compare shortly after the edge.
    always @(posedge clk) begin
        int           w;
        logic [W-1:0] a1, b1, a2, b2;
        logic [W-1:0] dotV;
        edgeCount++;
        if (reset) begin
            modelPtr       = NREQ - 1;
            expQ.delete();
            modelMac       = '{default: '0};
            modelAccepts   = 0;
            modelConflicts = 0;
        end else begin
            w = pickWinner(bus.req_valid, modelPtr);
            if ($countones(bus.req_valid) >= 2) modelConflicts++;
            if (w >= 0) begin
                a1   = sliceOf(bus.req_a1, w);
                b1   = sliceOf(bus.req_b1, w);
                a2   = sliceOf(bus.req_a2, w);
                b2   = sliceOf(bus.req_b2, w);
                dotV = a1 * b1 + a2 * b2;
                modelPtr    = w;
                modelMac[0] = a1;
                modelMac[1] = b1;
                modelMac[2] = a2;
                modelMac[3] = b2;
                expQ.push_back('{edgeCount + LAT, w, dotV});
                modelAccepts++;
            end
        end
        #2;
        checkOutput();
    end

    task automatic setReq(input int i, input logic [W-1:0] a1, input logic [W-1:0] b1,
                          input logic [W-1:0] a2, input logic [W-1:0] b2);
        bus.req_a1[i*W +: W] = a1;
        bus.req_b1[i*W +: W] = b1;
        bus.req_a2[i*W +: W] = a2;
        bus.req_b2[i*W +: W] = b2;
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic rst);
        bus.req_valid = valid;
        reset         = rst;
    endtask

    task automatic pulseReset();
        applyStimulus('0, 1'b1);
        @(negedge clk);
        applyStimulus('0, 1'b0);
    endtask

    initial begin
`ifdef DOT2_ARB_PERF_EN
        logic [31:0] confBase;
        logic [31:0] accBase;
`endif
        bus.req_a1 = '0;
        bus.req_b1 = '0;
        bus.req_a2 = '0;
        bus.req_b2 = '0;
        applyStimulus('0, 1'b1);

        // Reset held two cycles with no requests.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checkEq("reset_ready", 64'(bus.req_ready), 64'd0);
            checkEq("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
            checkEq("reset_mac_a1", 64'(bus.mac_a1), 64'd0);
            checkEq("reset_mac_b2", 64'(bus.mac_b2), 64'd0);
        end
        applyStimulus('0, 1'b0);

        // Single request from requester 0: 3*4 + 5*6 = 42.
        @(negedge clk);
        setReq(0, 32'd3, 32'd4, 32'd5, 32'd6);
        applyStimulus(4'b0001, 1'b0);
        #1 checkEq("single_ready", 64'(bus.req_ready), 64'b0001);
        @(negedge clk);
        applyStimulus('0, 1'b0);
        @(negedge clk);
        checkEq("single_early", 64'(bus.rsp_valid), 64'd0);
        @(negedge clk);
        checkEq("single_valid", 64'(bus.rsp_valid), 64'd1);
        checkEq("single_id", 64'(bus.rsp_id), 64'd0);
        checkEq("single_data", 64'(bus.rsp_data), 64'd42);

        // All four requesters continuously valid: grants rotate 0,1,2,3,...
        pulseReset();
        for (int i = 0; i < NREQ; i++) setReq(i, W'(i + 1), 32'd2, 32'd0, 32'd0);
        applyStimulus(4'b1111, 1'b0);
        for (int j = 0; j < 8; j++) begin
            #1 checkEq("rr_grant", 64'(bus.req_ready), 64'(4'b0001 << (j % 4)));
            if (j >= 3) begin
                checkEq("rr_rsp_valid", 64'(bus.rsp_valid), 64'd1);
                checkEq("rr_rsp_id", 64'(bus.rsp_id), 64'((j - 3) % 4));
                checkEq("rr_rsp_data", 64'(bus.rsp_data), 64'(2 * ((j - 3) % 4 + 1)));
            end
            @(negedge clk);
        end
        applyStimulus('0, 1'b0);

        // Requesters 1 and 3 with the pointer parked on 1: grant 3, then 1.
        pulseReset();
        applyStimulus(4'b0010, 1'b0);
        @(negedge clk);
        applyStimulus(4'b1010, 1'b0);
`ifdef DOT2_ARB_PERF_EN
        confBase = perfConflicts;
        accBase  = perfAccepts;
`endif
        #1 checkEq("pair_first", 64'(bus.req_ready), 64'b1000);
        @(negedge clk);
        checkEq("pair_second", 64'(bus.req_ready), 64'b0010);
        @(negedge clk);
        applyStimulus('0, 1'b0);
`ifdef DOT2_ARB_PERF_EN
        checkEq("perf_conflict_delta", 64'(perfConflicts - confBase), 64'd2);
        checkEq("perf_accept_delta", 64'(perfAccepts - accBase), 64'd2);
`endif

        // Wrap: 0xFFFFFFFF*2 + 1*1 = 0x1_FFFF_FFFF -> 0xFFFFFFFF mod 2^32.
        @(negedge clk);
        setReq(2, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'd1);
        applyStimulus(4'b0100, 1'b0);
        @(negedge clk);
        applyStimulus('0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checkEq("wrap_valid", 64'(bus.rsp_valid), 64'd1);
        checkEq("wrap_id", 64'(bus.rsp_id), 64'd2);
        checkEq("wrap_data", 64'(bus.rsp_data), 64'h0000_0000_FFFF_FFFF);

        // Two accepts in flight, then reset: both responses are discarded.
        setReq(0, 32'd7, 32'd7, 32'd1, 32'd1);
        setReq(1, 32'd9, 32'd9, 32'd2, 32'd2);
        applyStimulus(4'b0011, 1'b0);
        @(negedge clk);
        @(negedge clk);
        applyStimulus('0, 1'b1);
        @(negedge clk);
        applyStimulus('0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            checkEq("flush_rsp_valid", 64'(bus.rsp_valid), 64'd0);
            @(negedge clk);
        end
        applyStimulus(4'b1111, 1'b0);
        #1 checkEq("post_reset_grant", 64'(bus.req_ready), 64'b0001);
        @(negedge clk);
        applyStimulus('0, 1'b0);

        // Random traffic with occasional resets.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    setReq(i, $urandom, $urandom, $urandom, $urandom);
                end else begin
                    setReq(i, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                           W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
                end
            end
            applyStimulus(NREQ'($urandom_range(0, 15)), ($urandom_range(0, 39) == 0));
        end
        @(negedge clk);
        applyStimulus('0, 1'b0);
        repeat (LAT + 3) @(negedge clk);
        checkEq("drain_queue_empty", 64'(expQ.size()), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
